// File: rtl/nios2os_nios2_jtag_debug_sysclk_v2.sv
// rtl/nios2os_nios2_jtag_debug_sysclk_v2.sv - system-clock side JTAG debug command receiver
module nios2os_nios2_jtag_debug_sysclk_v2 #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 35
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DR_W-1:0]      sr,
  input  logic                 cmd_ready,
  input  logic                 overrun_clr,
  output logic [DR_W-1:0]      jdo,
  output logic [IR_W-1:0]      cmd_ir,
  output logic                 cmd_valid,
  output logic [(1<<IR_W)-1:0] take_action,
  output logic [(1<<IR_W)-1:0] take_no_action,
  output logic                 ir_update,
  output logic                 overrun
);

  localparam int N_CH = 1 << IR_W;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  // Shifts in ones after reset; its top bit says the chains now hold real samples.
  logic [SYNC_STAGES-1:0] fill;
  logic                   udr_prev, uir_prev;
  logic                   udr_armed, uir_armed;
  logic                   udr_s, uir_s, fill_done;
  logic                   udr_edge, uir_edge;

  logic                   capture, ovr_set;
  logic [DR_W-1:0]        nxt_jdo;
  logic [IR_W-1:0]        nxt_ir;
  logic [N_CH-1:0]        ta_nxt, tna_nxt;

  assign udr_s     = udr_sync[SYNC_STAGES-1];
  assign uir_s     = uir_sync[SYNC_STAGES-1];
  assign fill_done = fill[SYNC_STAGES-1];

  // A channel only fires after its synchronised level was seen low with a filled chain,
  // so a strobe held high across reset release stays silent until it toggles.
  assign udr_edge = udr_armed & udr_s & ~udr_prev;
  assign uir_edge = uir_armed & uir_s & ~uir_prev;

  assign cmd_valid = (state == PENDING);

  // Strobe synchronisers, edge history and arming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync  <= '0;
      uir_sync  <= '0;
      fill      <= '0;
      udr_prev  <= 1'b0;
      uir_prev  <= 1'b0;
      udr_armed <= 1'b0;
      uir_armed <= 1'b0;
    end else begin
      udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      udr_prev  <= udr_s;
      uir_prev  <= uir_s;
      udr_armed <= udr_armed | (fill_done & ~udr_s);
      uir_armed <= uir_armed | (fill_done & ~uir_s);
    end
  end

  // Command state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: capture on a udr edge unless a command is still held without ready.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (udr_edge) begin
          capture   = 1'b1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (cmd_ready) begin
          if (udr_edge) capture = 1'b1;
          else          state_nxt = IDLE;
        end else if (udr_edge) begin
          ovr_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next command contents and one-hot qualifiers, registered so they never glitch.
  always_comb begin
    nxt_jdo = capture ? sr    : jdo;
    nxt_ir  = capture ? ir_in : cmd_ir;
    ta_nxt  = '0;
    tna_nxt = '0;
    for (int k = 0; k < N_CH; k++) begin
      if ((state_nxt == PENDING) && (nxt_ir == IR_W'(k))) begin
        ta_nxt[k]  = nxt_jdo[ACT_BIT];
        tna_nxt[k] = ~nxt_jdo[ACT_BIT];
      end
    end
  end

  // Captured command and qualifier registers; data holds after acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      cmd_ir         <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      jdo            <= nxt_jdo;
      cmd_ir         <= nxt_ir;
      take_action    <= ta_nxt;
      take_no_action <= tna_nxt;
    end
  end

  // IR update pulse, independent of the command path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ir_update <= 1'b0;
    else          ir_update <= uir_edge;
  end

  // Sticky overrun; a new drop outranks a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         overrun <= 1'b0;
    else if (ovr_set)     overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_nios2os_nios2_jtag_debug_sysclk_v2.sv
// tb/tb_nios2os_nios2_jtag_debug_sysclk_v2.sv - table-driven bench for the sysclk debug command receiver
module tb_nios2os_nios2_jtag_debug_sysclk_v2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_udr, vs_uir, cmd_ready, overrun_clr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic [37:0] jdo;
  logic [1:0]  cmd_ir;
  logic        cmd_valid, ir_update, overrun;
  logic [3:0]  take_action, take_no_action;

  logic        udr2, uir2, rdy2, clr2;
  logic [2:0]  ir2;
  logic [15:0] sr2;
  logic [15:0] jdo2;
  logic [2:0]  cmd_ir2;
  logic        valid2, iru2, ovr2;
  logic [7:0]  ta2, tna2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios2os_nios2_jtag_debug_sysclk_v2 #(.IR_W(2), .DR_W(38), .SYNC_STAGES(2), .ACT_BIT(35)) u_dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_ready(cmd_ready), .overrun_clr(overrun_clr), .jdo(jdo), .cmd_ir(cmd_ir),
    .cmd_valid(cmd_valid), .take_action(take_action), .take_no_action(take_no_action),
    .ir_update(ir_update), .overrun(overrun));

  nios2os_nios2_jtag_debug_sysclk_v2 #(.IR_W(3), .DR_W(16), .SYNC_STAGES(3), .ACT_BIT(15)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .vs_udr(udr2), .vs_uir(uir2), .ir_in(ir2), .sr(sr2),
    .cmd_ready(rdy2), .overrun_clr(clr2), .jdo(jdo2), .cmd_ir(cmd_ir2),
    .cmd_valid(valid2), .take_action(ta2), .take_no_action(tna2),
    .ir_update(iru2), .overrun(ovr2));

  typedef struct {
    logic        udr, uir;
    logic [1:0]  ir;
    logic [37:0] sr;
    logic        rdy, clr;
    logic        ev;
    logic [1:0]  eir;
    logic [37:0] ejdo;
    logic [3:0]  eta, etna;
    logic        eiru, eovr;
  } vec_t;

  vec_t vecs[160];
  int   n_vec = 0;

  localparam logic [37:0] SA  = 38'h28_0000_00AB;
  localparam logic [37:0] SB  = 38'h00_0000_0055;
  localparam logic [37:0] SC1 = 38'h08_0000_0011;
  localparam logic [37:0] SC2 = 38'h00_0000_0022;
  localparam logic [37:0] SC3 = 38'h3F_FFFF_FFFF;
  localparam logic [37:0] SD1 = 38'h20_0000_0001;
  localparam logic [37:0] SD2 = 38'h08_0000_0002;
  localparam logic [37:0] SE  = 38'h15_5555_5555;

  function automatic void add(input int n, input logic udr, input logic uir, input logic [1:0] ir,
                              input logic [37:0] s, input logic rdy, input logic clr,
                              input logic ev, input logic [1:0] eir, input logic [37:0] ejdo,
                              input logic [3:0] eta, input logic [3:0] etna,
                              input logic eiru, input logic eovr);
    for (int i = 0; i < n; i++) begin
      vecs[n_vec] = '{udr, uir, ir, s, rdy, clr, ev, eir, ejdo, eta, etna, eiru, eovr};
      n_vec++;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack1();
    return {13'b0, jdo, cmd_ir, cmd_valid, take_action, take_no_action, ir_update, overrun};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic seen;
    logic [63:0] exp;

    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; overrun_clr = 1'b0;
    udr2 = 1'b0; uir2 = 1'b0; ir2 = '0; sr2 = '0; rdy2 = 1'b0; clr2 = 1'b0;

    // idle while arming
    add(4, 0, 0, '0, '0, 0, 0,   0, '0, '0, '0, '0, 0, 0);
    // single action command, ready high
    add(2, 1, 0, 2'd2, SA, 1, 0, 0, '0, '0, '0, '0, 0, 0);
    add(1, 1, 0, 2'd2, SA, 1, 0, 1, 2'd2, SA, 4'b0100, '0, 0, 0);
    add(1, 1, 0, 2'd2, SA, 1, 0, 0, 2'd2, SA, '0, '0, 0, 0);
    add(4, 0, 0, 2'd2, SA, 1, 0, 0, 2'd2, SA, '0, '0, 0, 0);
    // no-action command held under backpressure
    add(2, 1, 0, 2'd1, SB, 0, 0, 0, 2'd2, SA, '0, '0, 0, 0);
    add(2, 1, 0, 2'd1, SB, 0, 0, 1, 2'd1, SB, '0, 4'b0010, 0, 0);
    add(8, 0, 0, 2'd1, SB, 0, 0, 1, 2'd1, SB, '0, 4'b0010, 0, 0);
    add(2, 0, 0, 2'd1, SB, 1, 0, 0, 2'd1, SB, '0, '0, 0, 0);
    // pending command then a dropped one
    add(2, 1, 0, 2'd3, SC1, 0, 0, 0, 2'd1, SB, '0, '0, 0, 0);
    add(2, 1, 0, 2'd3, SC1, 0, 0, 1, 2'd3, SC1, 4'b1000, '0, 0, 0);
    add(3, 0, 0, 2'd3, SC1, 0, 0, 1, 2'd3, SC1, 4'b1000, '0, 0, 0);
    add(2, 1, 0, 2'd0, SC2, 0, 0, 1, 2'd3, SC1, 4'b1000, '0, 0, 0);
    add(2, 1, 0, 2'd0, SC2, 0, 0, 1, 2'd3, SC1, 4'b1000, '0, 0, 1);
    add(3, 0, 0, 2'd0, SC2, 0, 0, 1, 2'd3, SC1, 4'b1000, '0, 0, 1);
    add(1, 0, 0, 2'd0, SC2, 0, 1, 1, 2'd3, SC1, 4'b1000, '0, 0, 0);
    add(1, 0, 0, 2'd0, SC2, 0, 0, 1, 2'd3, SC1, 4'b1000, '0, 0, 0);
    // drop coincident with clear: set wins
    add(2, 1, 0, 2'd0, SC3, 0, 0, 1, 2'd3, SC1, 4'b1000, '0, 0, 0);
    add(1, 1, 0, 2'd0, SC3, 0, 1, 1, 2'd3, SC1, 4'b1000, '0, 0, 1);
    add(1, 1, 0, 2'd0, SC3, 0, 0, 1, 2'd3, SC1, 4'b1000, '0, 0, 1);
    add(3, 0, 0, 2'd0, SC3, 0, 0, 1, 2'd3, SC1, 4'b1000, '0, 0, 1);
    add(1, 0, 0, 2'd0, SC3, 1, 0, 0, 2'd3, SC1, '0, '0, 0, 1);
    add(1, 0, 0, 2'd0, SC3, 0, 1, 0, 2'd3, SC1, '0, '0, 0, 0);
    // back-to-back capture on the accepting edge
    add(2, 1, 0, 2'd0, SD1, 0, 0, 0, 2'd3, SC1, '0, '0, 0, 0);
    add(2, 1, 0, 2'd0, SD1, 0, 0, 1, 2'd0, SD1, '0, 4'b0001, 0, 0);
    add(3, 0, 0, 2'd0, SD1, 0, 0, 1, 2'd0, SD1, '0, 4'b0001, 0, 0);
    add(2, 1, 0, 2'd1, SD2, 0, 0, 1, 2'd0, SD1, '0, 4'b0001, 0, 0);
    add(1, 1, 0, 2'd1, SD2, 1, 0, 1, 2'd1, SD2, 4'b0010, '0, 0, 0);
    add(1, 1, 0, 2'd1, SD2, 0, 0, 1, 2'd1, SD2, 4'b0010, '0, 0, 0);
    add(1, 0, 0, 2'd1, SD2, 1, 0, 0, 2'd1, SD2, '0, '0, 0, 0);
    add(2, 0, 0, 2'd1, SD2, 0, 0, 0, 2'd1, SD2, '0, '0, 0, 0);
    // IR update pulse
    add(2, 0, 1, 2'd1, SD2, 0, 0, 0, 2'd1, SD2, '0, '0, 0, 0);
    add(1, 0, 1, 2'd1, SD2, 0, 0, 0, 2'd1, SD2, '0, '0, 1, 0);
    add(1, 0, 1, 2'd1, SD2, 0, 0, 0, 2'd1, SD2, '0, '0, 0, 0);
    add(3, 0, 0, 2'd1, SD2, 0, 0, 0, 2'd1, SD2, '0, '0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", pack1(), 64'd0);
    check("reset_outputs2", 64'({jdo2, cmd_ir2, valid2, ta2, tna2, iru2, ovr2}), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      vs_udr = vecs[i].udr; vs_uir = vecs[i].uir; ir_in = vecs[i].ir; sr = vecs[i].sr;
      cmd_ready = vecs[i].rdy; overrun_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      exp = {13'b0, vecs[i].ejdo, vecs[i].eir, vecs[i].ev, vecs[i].eta, vecs[i].etna,
             vecs[i].eiru, vecs[i].eovr};
      check($sformatf("row%0d", i), pack1(), exp);
    end
    vs_uir = 1'b0; overrun_clr = 1'b0;

    // reset while a command is pending clears everything at once
    sr = SA; ir_in = 2'd2; cmd_ready = 1'b0; vs_udr = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cmd_valid && n < 10);
    check("pending_latency", 64'(n), 64'd3);
    vs_udr = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", pack1(), 64'd0);

    // strobe held high through reset release
    vs_udr = 1'b1; sr = SE; ir_in = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen = seen | cmd_valid | (|take_action) | (|take_no_action);
    end
    check("held_high_no_cmd", 64'(seen), 64'd0);
    vs_udr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vs_udr = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cmd_valid && n < 10);
    check("rearm_latency", 64'(n), 64'd3);
    check("rearm_jdo", 64'(jdo), 64'(SE));
    check("rearm_tna", 64'(take_no_action), 64'd1);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rearm_accept", 64'(cmd_valid), 64'd0);
    vs_udr = 1'b0; cmd_ready = 1'b0;

    // wide-parameter instance
    ir2 = 3'd7; sr2 = 16'h8001; rdy2 = 1'b0; udr2 = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!valid2 && n < 10);
    check("p2_latency", 64'(n), 64'd4);
    check("p2_take_action", 64'({ta2, tna2}), 64'h8000);
    check("p2_jdo", 64'({cmd_ir2, jdo2}), 64'h78001);
    rdy2 = 1'b1;
    @(posedge clk);
    #1;
    check("p2_accept", 64'({valid2, ta2}), 64'd0);
    udr2 = 1'b0; rdy2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    uir2 = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!iru2 && n < 10);
    check("p2_ir_update_latency", 64'(n), 64'd4);
    @(posedge clk);
    #1;
    check("p2_ir_update_pulse", 64'({iru2, valid2, ovr2}), 64'd0);
    uir2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
